// File: rtl/led_arbiter.sv
// Round-robin time-slicing arbiter that shares the active-low LED bank between four requesters.
// Define LED_ARB_IDLE_ROTATE_EN to show a rotating idle pattern; otherwise the idle bank is dark.
module led_arbiter #(
    parameter logic [26:0] TICK_CYCLES = 27'd38_196_600,
    parameter logic [3:0]  SLOT_TICKS  = 4'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] pattern,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [15:0] led_controller
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // A zero-length slot behaves as a one-tick slot.
    localparam logic [3:0] SLOT_LAST = (SLOT_TICKS == 4'd0) ? 4'd0 : SLOT_TICKS - 4'd1;

`ifdef LED_ARB_IDLE_ROTATE_EN
    localparam logic [15:0] LED_RESET = 16'hfffe;
`else
    localparam logic [15:0] LED_RESET = 16'hffff;
`endif

    state_t      state, state_next;
    logic [26:0] count;
    logic        tick;
    logic [1:0]  last, last_next;
    logic [3:0]  slot_cnt, slot_next;
    logic [3:0]  grant_next;
    logic        busy_next;
    logic [15:0] led_next;
    logic [15:0] idle_show;
    logic        found;
    logic [1:0]  winner;

    assign tick = (count == TICK_CYCLES);

    // Search upward from last+1; the current owner (== last) is considered last of all.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        found  = 1'b0;
        winner = last;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[last + 2'(i)]) begin
                found  = 1'b1;
                winner = last + 2'(i);
            end
        end
    end

`ifdef LED_ARB_IDLE_ROTATE_EN
    logic [15:0] idle_pat, idle_next;

    always_comb begin
        idle_next = idle_pat;
        if (state == IDLE && !found && tick)
            idle_next = {idle_pat[14:0], idle_pat[15]};
    end

    assign idle_show = idle_next;

    always_ff @(posedge clock) begin
        if (!reset) idle_pat <= 16'hfffe;
        else        idle_pat <= idle_next;
    end
`else
    assign idle_show = 16'hffff;
`endif

    always_comb begin
        state_next = state;
        last_next  = last;
        slot_next  = slot_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    last_next  = winner;
                    slot_next  = 4'd0;
                end
            end
            GRANT: begin
                if (!req[last]) begin
                    slot_next = 4'd0;
                    if (found) last_next  = winner;
                    else       state_next = IDLE;
                end else if (tick && slot_cnt == SLOT_LAST) begin
                    // Owner still requesting, so the search always finds someone (possibly itself).
                    slot_next = 4'd0;
                    last_next = winner;
                end else if (tick) begin
                    slot_next = slot_cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        grant_next = (state_next == GRANT) ? (4'b0001 << last_next) : 4'b0000;
        busy_next  = (state_next == GRANT);
        led_next   = (state_next == GRANT) ? pattern[{last_next, 4'b0000} +: 16] : idle_show;
    end

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so all state updates together at the edge.
        if (!reset) begin
            state          <= IDLE;
            count          <= 27'd0;
            last           <= 2'd3;
            slot_cnt       <= 4'd0;
            grant          <= 4'b0000;
            busy           <= 1'b0;
            led_controller <= LED_RESET;
        end else begin
            state          <= state_next;
            count          <= tick ? 27'd0 : count + 27'd1;
            last           <= last_next;
            slot_cnt       <= slot_next;
            grant          <= grant_next;
            busy           <= busy_next;
            led_controller <= led_next;
        end
    end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Time-slicing arbiter that shares the 16-bit active-low LED bank between four requesters. Each requester presents a 16-bit pattern. The block grants the bank round-robin for a minimum slot measured in prescaler ticks, and drives `led_controller` from the current owner. When no requester is active it shows an idle pattern. It sits between the board LED pins and the blocks that want to display status.

## Interface
- `TICK_CYCLES`, 27'd38_196_600, terminal value of the tick prescaler; tick period is TICK_CYCLES+1 cycles.
- `SLOT_TICKS`, 4'd3, minimum grant length in ticks; 0 is treated as 1.
- `clock` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low.
- `req` input 4: per-requester level request; bit i = requester i.
- `pattern` input 64: requester i pattern at [16*i+15:16*i], active-low LEDs.
- `grant` output 4: registered one-hot owner; 0 when idle.
- `busy` output 1: registered, 1 while in GRANT.
- `led_controller` output 16: registered LED drive, active-low.

## Operation
- Prescaler: 27-bit `count`, free-running in both states. `tick` is high when `count == TICK_CYCLES`; `count` then wraps to 0, otherwise it increments. The prescaler is never cleared by a grant.
- Round-robin pointer `last` (2 bits): the search starts at `last+1` and goes upward modulo 4. `last` updates to the index of every new grant.
- State IDLE:
  - If any `req` is set: grant the winner, go to GRANT, clear `slot_cnt` to 0.
  - Otherwise: on each tick, rotate `idle_pat` left by 1 (bit 15 goes to bit 0).
- State GRANT, evaluated in this priority order:
  1. Owner's `req` is low (release): grant the next requester in the round-robin search. If there is none, go to IDLE. `slot_cnt` is cleared to 0 in either case.
  2. `tick` and `slot_cnt == SLOT_TICKS-1` (slot expiry): grant the next requester if another `req` bit is set. Otherwise keep the current owner. In both cases, clear `slot_cnt` to 0.
  3. `tick` with no expiry: increment `slot_cnt`.
- Output register `led_controller`:
  - GRANT: owner's `pattern` slice.
  - IDLE: `idle_pat`.
  - It updates every cycle, so pattern changes are tracked while the grant is held.
- `idle_pat` holds its value while in GRANT and resumes rotating from that value on return to IDLE.
- Requests are level-sensitive and not latched. A requester dropping `req` before it is granted loses its place without any record.
- `slot_cnt` is 4 bits and cannot exceed SLOT_TICKS-1.

## Timing
- Reset values:
  - state IDLE
  - `grant` = 4'b0000, `busy` = 0
  - `last` = 2'd3, so requester 0 wins first after reset
  - `count` = 0, `slot_cnt` = 0
  - `idle_pat` = 16'hfffe
  - `led_controller` = 16'hfffe with the macro, 16'hffff without it
- Reset mid-grant returns all registers to these reset values at the next edge.
- Grant latency: `req` sampled high at edge N (IDLE) gives `grant`, `busy` and `led_controller` = pattern, all valid after edge N.
- Handover on release: the new owner's `grant` and pattern appear at the same edge that removes the old owner. There is no gap cycle.
- Handover on expiry: occurs at the tick edge.
- Owner release on the expiry tick: the release rule applies.
- Pattern tracking latency while granted: 1 cycle.

## Configuration
- `LED_ARB_IDLE_ROTATE_EN` defined:
  - IDLE displays the rotating `idle_pat` as described above.
  - Reset value of `led_controller` is 16'hfffe.
- `LED_ARB_IDLE_ROTATE_EN` undefined:
  - `idle_pat` logic is removed.
  - IDLE drives `led_controller` = 16'hffff (all LEDs off).
  - Reset value of `led_controller` is 16'hffff.
  - Arbitration behaviour is unchanged.

## Test plan
Bench parameters: TICK_CYCLES=3 (tick every 4 cycles), SLOT_TICKS=2, macro defined.

- Reset, then no `req` for 16 cycles -> `led_controller` goes 16'hfffe, 16'hfffd, 16'hfffb, 16'hfff7, advancing one step per tick; `grant` = 0, `busy` = 0.
- `req` = 4'b0101 asserted simultaneously after reset, patterns 16'h00ff / 16'h0f0f -> requester 0 is granted first (`led_controller` = 16'h00ff). After 2 ticks, `grant` = 4'b0100 and `led_controller` = 16'h0f0f. After 2 more ticks, `grant` = 4'b0001.
- Single `req[2]` held for 10 ticks -> `grant` stays 4'b0100 with no gaps through each expiry.
- Owner `req[1]` drops mid-slot while `req[3]` is high -> on the next edge, `grant` = 4'b1000, `slot_cnt` restarts, and `led_controller` = pattern3.
- Owner drops with no other request -> IDLE next edge, `busy` = 0, and idle rotation resumes from the frozen `idle_pat`.
- Reset asserted mid-grant -> the next edge gives `grant` = 0, `led_controller` = 16'hfffe, and requester 0 has priority again.
